arp_phase_gen: RTL

Parametrised arpeggiator and phase-accumulator (DDS) front end for the audio path. It produces the sine-table read address that feeds the BRAM and, through it, the PWM stage. With arpeggiation enabled, it steps through NOTES pitch ratios of a base tuning word in a selectable pattern. With arpeggiation disabled, it holds the base note.

---
 rtl/arp_phase_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/arp_phase_gen.sv
// Arpeggiator and DDS phase accumulator feeding the sine-table address.
// Optional `ARP_PHASE_SYNC_EN: hard-sync the accumulator to 0 on each note.
module arp_phase_gen #(
  parameter  int ADDR_W     = 8,
  parameter  int ACC_W      = 24,
  parameter  int NOTES      = 4,
  parameter  int SAMPLE_DIV = 1024,
  parameter  int DWELL      = 25000000,
  localparam int NOTE_W     = (NOTES > 1) ? $clog2(NOTES) : 1
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              arp_en,
  input  logic [1:0]        mode,
  input  logic [ACC_W-1:0]  base_inc,
  output logic [ADDR_W-1:0] addr,
  output logic [NOTE_W-1:0] note,
  output logic              step_pulse,
  output logic              sample_tick
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW_W  = $clog2(DWELL);

  localparam logic [DIV_W-1:0]  DIV_TC = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DW_W-1:0]   DW_TC  = DW_W'(DWELL - 1);
  localparam logic [NOTE_W-1:0] N_TOP  = NOTE_W'(NOTES - 1);

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DN   = 2'b01;
  localparam logic [1:0] M_UD   = 2'b10;
  localparam logic [1:0] M_HOLD = 2'b11;

  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_nxt;
  logic              tick_q;
  logic              tick_nxt;

  logic [DW_W-1:0]   dw_q;
  logic [DW_W-1:0]   dw_nxt;
  logic              dw_tc;

  logic [NOTE_W-1:0] note_q;
  logic [NOTE_W-1:0] note_nxt;
  logic [NOTE_W-1:0] note_adv;
  logic              dir_q;
  logic              dir_nxt;
  logic              dir_adv;
  logic              eff_up;
  logic              step_q;
  logic              step_nxt;

  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_nxt;
  logic [ACC_W-1:0]  inc_q;
  logic [ACC_W-1:0]  inc_nxt;
  logic [ACC_W+2:0]  b_ext;
  logic [ACC_W+2:0]  ratio;
  logic [NOTE_W+1:0] k_ext;

`ifdef ARP_PHASE_SYNC_EN
  logic en_q;
  logic sync_clr;
`endif

  // sample divider; tick is registered so it is low while in reset
  always_comb begin
    div_nxt  = (div_q == DIV_TC) ? '0 : div_q + 1'b1;
    tick_nxt = (div_nxt == DIV_TC);
  end

  // endpoints force the up-down direction so the next note stays in range
  always_comb begin
    eff_up = dir_q;
    if (note_q == '0)
      eff_up = 1'b1;
    else if (note_q == N_TOP)
      eff_up = 1'b0;
  end

  always_comb begin
    note_adv = note_q;
    dir_adv  = dir_q;
    unique case (1'b1)
      (mode == M_UP):
        note_adv = (note_q == N_TOP) ? '0 : note_q + 1'b1;
      (mode == M_DN):
        note_adv = (note_q == '0) ? N_TOP : note_q - 1'b1;
      (mode == M_UD): begin
        note_adv = eff_up ? note_q + 1'b1 : note_q - 1'b1;
        dir_adv  = eff_up;
      end
      (mode == M_HOLD):
        note_adv = note_q;
    endcase
  end

  // disable wins over a coincident step boundary
  always_comb begin
    dw_tc    = (dw_q == DW_TC);
    dw_nxt   = '0;
    note_nxt = '0;
    dir_nxt  = dir_q;
    step_nxt = 1'b0;
    if (arp_en) begin
      dw_nxt   = dw_tc ? '0 : dw_q + 1'b1;
      note_nxt = note_q;
      if (dw_tc && (mode != M_HOLD)) begin
        note_nxt = note_adv;
        dir_nxt  = dir_adv;
        step_nxt = 1'b1;
      end
    end
  end

  // ratio r(k mod 4) scaled by octave k/4, wrapped to ACC_W bits
  always_comb begin
    b_ext = {3'b000, base_inc};
    k_ext = {2'b00, note_q};
    unique case (k_ext[1:0])
      2'd0: ratio = b_ext;
      2'd1: ratio = b_ext + (b_ext >> 2);
      2'd2: ratio = b_ext + (b_ext >> 1);
      2'd3: ratio = b_ext << 1;
    endcase
    inc_nxt = ACC_W'(ratio << k_ext[NOTE_W+1:2]);
  end

  always_comb begin
    acc_nxt = tick_q ? acc_q + inc_q : acc_q;
`ifdef ARP_PHASE_SYNC_EN
    sync_clr = step_nxt | (arp_en & ~en_q);
    if (sync_clr)
      acc_nxt = '0;
`endif
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_q  <= '0;
      tick_q <= 1'b0;
      dw_q   <= '0;
      note_q <= '0;
      dir_q  <= 1'b1;
      step_q <= 1'b0;
      inc_q  <= '0;
      acc_q  <= '0;
    end else begin
      div_q  <= div_nxt;
      tick_q <= tick_nxt;
      dw_q   <= dw_nxt;
      note_q <= note_nxt;
      dir_q  <= dir_nxt;
      step_q <= step_nxt;
      inc_q  <= inc_nxt;
      acc_q  <= acc_nxt;
    end
  end

`ifdef ARP_PHASE_SYNC_EN
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)
      en_q <= 1'b0;
    else
      en_q <= arp_en;
  end
`endif

  assign addr        = acc_q[ACC_W-1 -: ADDR_W];
  assign note        = note_q;
  assign step_pulse  = step_q;
  assign sample_tick = tick_q;

endmodule
